// File: rtl/pipe_core_fwd.sv
`default_nettype none
// ============================================================================
// Module   : pipe_core_fwd
// Brief    : Parametrised five-stage in-order core (IF/ID/EX/MEM/WB) with
//            EX-stage forwarding, load-use stall, EX branch resolution and
//            a retired-instruction counter. ADV gates every state update.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_core_fwd #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ADV,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [3:0]        dbg_ra,
    output logic [DATA_W-1:0] dbg_rd,
    output logic              stall,
    output logic              flush,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [3:0] c_OP_NOP  = 4'd0;
    localparam logic [3:0] c_OP_ADD  = 4'd1;
    localparam logic [3:0] c_OP_SUB  = 4'd2;
    localparam logic [3:0] c_OP_AND  = 4'd3;
    localparam logic [3:0] c_OP_OR   = 4'd4;
    localparam logic [3:0] c_OP_LI   = 4'd5;
    localparam logic [3:0] c_OP_LD   = 4'd6;
    localparam logic [3:0] c_OP_ST   = 4'd7;
    localparam logic [3:0] c_OP_BEQZ = 4'd8;

    // Ops that produce a register result (ALU, LI, LD).
    function automatic logic f_writes(input logic [3:0] op);
        return (op >= c_OP_ADD) && (op <= c_OP_LD);
    endfunction

    // ALU ops write field c; LI and LD write field a.
    function automatic logic [3:0] f_dest(input logic [3:0] op,
                                          input logic [3:0] a,
                                          input logic [3:0] c);
        return (op >= c_OP_ADD && op <= c_OP_OR) ? c : a;
    endfunction

    function automatic logic f_reads_a(input logic [3:0] op);
        return (op >= c_OP_ADD && op <= c_OP_OR) || (op == c_OP_ST) || (op == c_OP_BEQZ);
    endfunction

    function automatic logic f_reads_b(input logic [3:0] op);
        return (op >= c_OP_ADD && op <= c_OP_OR) || (op == c_OP_LD) || (op == c_OP_ST);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ifid_instr;

    logic [3:0]        r_idex_op;
    logic [3:0]        r_idex_a;
    logic [3:0]        r_idex_b;
    logic [3:0]        r_idex_c;
    logic [7:0]        r_idex_imm;
    logic [DATA_W-1:0] r_idex_va;
    logic [DATA_W-1:0] r_idex_vb;

    logic [3:0]        r_exmem_op;
    logic [3:0]        r_exmem_dest;
    logic              r_exmem_wr;
    logic [DATA_W-1:0] r_exmem_res;
    logic [ADDR_W-1:0] r_exmem_addr;
    logic [DATA_W-1:0] r_exmem_sdata;

    logic [3:0]        r_memwb_op;
    logic [3:0]        r_memwb_dest;
    logic              r_memwb_wr;
    logic [DATA_W-1:0] r_memwb_val;

    logic [DATA_W-1:0] r_rf [16];
    logic [CNT_W-1:0]  r_retired;

    // ------------------------------------------------------------------
    // ID stage: decode and register read with write-through from WB
    // ------------------------------------------------------------------
    logic [3:0]        w_id_op;
    logic [3:0]        w_id_a;
    logic [3:0]        w_id_b;
    logic [3:0]        w_id_c;
    logic [7:0]        w_id_imm;
    logic [DATA_W-1:0] w_id_va;
    logic [DATA_W-1:0] w_id_vb;

    assign w_id_op  = r_ifid_instr[15:12];
    assign w_id_a   = r_ifid_instr[11:8];
    assign w_id_b   = r_ifid_instr[7:4];
    assign w_id_c   = r_ifid_instr[3:0];
    assign w_id_imm = r_ifid_instr[7:0];

    assign w_id_va = (r_memwb_wr && (r_memwb_dest == w_id_a)) ? r_memwb_val : r_rf[w_id_a];
    assign w_id_vb = (r_memwb_wr && (r_memwb_dest == w_id_b)) ? r_memwb_val : r_rf[w_id_b];

    // A load in EX whose destination is a live source of the ID instruction.
    assign stall = (r_idex_op == c_OP_LD) &&
                   ((f_reads_a(w_id_op) && (w_id_a == r_idex_a)) ||
                    (f_reads_b(w_id_op) && (w_id_b == r_idex_a)));

    // ------------------------------------------------------------------
    // EX stage: operand forwarding, ALU, branch resolution
    // ------------------------------------------------------------------
    logic              w_exmem_fwd_ok;
    logic [DATA_W-1:0] w_mem_val;
    logic [DATA_W-1:0] w_ex_va;
    logic [DATA_W-1:0] w_ex_vb;
    logic [DATA_W-1:0] w_ex_sext;
    logic [DATA_W-1:0] w_ex_res;

    // Load data is not available until the MEM/WB register, so EX/MEM
    // only forwards non-load results.
    assign w_exmem_fwd_ok = r_exmem_wr && (r_exmem_op != c_OP_LD);
    assign w_mem_val      = (r_exmem_op == c_OP_LD) ? dmem_rdata : r_exmem_res;

    assign w_ex_va = (w_exmem_fwd_ok && (r_exmem_dest == r_idex_a)) ? r_exmem_res :
                     (r_memwb_wr && (r_memwb_dest == r_idex_a))     ? r_memwb_val :
                                                                      r_idex_va;
    assign w_ex_vb = (w_exmem_fwd_ok && (r_exmem_dest == r_idex_b)) ? r_exmem_res :
                     (r_memwb_wr && (r_memwb_dest == r_idex_b))     ? r_memwb_val :
                                                                      r_idex_vb;

    generate
        if (DATA_W > 8) begin : g_sext_wide
            assign w_ex_sext = {{(DATA_W-8){r_idex_imm[7]}}, r_idex_imm};
        end else begin : g_sext_narrow
            assign w_ex_sext = r_idex_imm;
        end
    endgenerate

    // ALU result for the op currently in EX.
    always_comb begin
        w_ex_res = '0;
        case (r_idex_op)
            c_OP_ADD: w_ex_res = w_ex_va + w_ex_vb;
            c_OP_SUB: w_ex_res = w_ex_va - w_ex_vb;
            c_OP_AND: w_ex_res = w_ex_va & w_ex_vb;
            c_OP_OR:  w_ex_res = w_ex_va | w_ex_vb;
            c_OP_LI:  w_ex_res = w_ex_sext;
            default:  w_ex_res = '0;
        endcase
    end

    assign flush = (r_idex_op == c_OP_BEQZ) && (w_ex_va == '0);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_addr  = r_pc;
    assign dmem_addr  = r_exmem_addr;
    assign dmem_wdata = r_exmem_sdata;
    assign dmem_we    = ADV && (r_exmem_op == c_OP_ST);
    assign dbg_rd     = r_rf[dbg_ra];
    assign retired    = r_retired;

    // Pipeline registers; a taken branch wins over a load-use stall.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc          <= '0;
            r_ifid_instr  <= '0;
            r_idex_op     <= c_OP_NOP;
            r_idex_a      <= '0;
            r_idex_b      <= '0;
            r_idex_c      <= '0;
            r_idex_imm    <= '0;
            r_idex_va     <= '0;
            r_idex_vb     <= '0;
            r_exmem_op    <= c_OP_NOP;
            r_exmem_dest  <= '0;
            r_exmem_wr    <= 1'b0;
            r_exmem_res   <= '0;
            r_exmem_addr  <= '0;
            r_exmem_sdata <= '0;
            r_memwb_op    <= c_OP_NOP;
            r_memwb_dest  <= '0;
            r_memwb_wr    <= 1'b0;
            r_memwb_val   <= '0;
        end else if (ADV) begin
            if (flush) begin
                r_pc         <= r_idex_imm[ADDR_W-1:0];
                r_ifid_instr <= '0;
            end else if (!stall) begin
                r_pc         <= r_pc + ADDR_W'(1);
                r_ifid_instr <= imem_rdata;
            end

            if (flush || stall) begin
                r_idex_op  <= c_OP_NOP;
                r_idex_a   <= '0;
                r_idex_b   <= '0;
                r_idex_c   <= '0;
                r_idex_imm <= '0;
                r_idex_va  <= '0;
                r_idex_vb  <= '0;
            end else begin
                r_idex_op  <= w_id_op;
                r_idex_a   <= w_id_a;
                r_idex_b   <= w_id_b;
                r_idex_c   <= w_id_c;
                r_idex_imm <= w_id_imm;
                r_idex_va  <= w_id_va;
                r_idex_vb  <= w_id_vb;
            end

            r_exmem_op    <= r_idex_op;
            r_exmem_dest  <= f_dest(r_idex_op, r_idex_a, r_idex_c);
            r_exmem_wr    <= f_writes(r_idex_op);
            r_exmem_res   <= w_ex_res;
            r_exmem_addr  <= w_ex_vb[ADDR_W-1:0];
            r_exmem_sdata <= w_ex_va;

            r_memwb_op    <= r_exmem_op;
            r_memwb_dest  <= r_exmem_dest;
            r_memwb_wr    <= r_exmem_wr;
            r_memwb_val   <= w_mem_val;
        end
    end

    // Register file write-back.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                r_rf[i] <= '0;
            end
        end else if (ADV && r_memwb_wr) begin
            r_rf[r_memwb_dest] <= r_memwb_val;
        end
    end

    // Count real instructions (ops 1-8) leaving WB.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_retired <= '0;
        end else if (ADV && (r_memwb_op >= c_OP_ADD) && (r_memwb_op <= c_OP_BEQZ)) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_core_fwd.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_core_fwd
// Brief    : Directed self-checking bench for pipe_core_fwd (default widths
//            plus a DATA_W=32 / ADDR_W=6 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_core_fwd;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ADV;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [7:0]  dmem_addr;
    logic [15:0] dmem_rdata;
    logic        dmem_we;
    logic [15:0] dmem_wdata;
    logic [3:0]  dbg_ra;
    logic [15:0] dbg_rd;
    logic        stall;
    logic        flush;
    logic [31:0] retired;

    logic        RST2;
    logic        ADV2;
    logic [5:0]  imem_addr2;
    logic [15:0] imem_rdata2;
    logic [5:0]  dmem_addr2;
    logic [31:0] dmem_rdata2;
    logic        dmem_we2;
    logic [31:0] dmem_wdata2;
    logic [3:0]  dbg_ra2;
    logic [31:0] dbg_rd2;
    logic        stall2;
    logic        flush2;
    logic [15:0] retired2;

    logic [15:0] imem  [256];
    logic [15:0] dmem  [256];
    logic [15:0] imem2 [64];

    int checks = 0;
    int errors = 0;
    int n_stall;
    int n_flush;
    int n_we;

    always #5 CLK = ~CLK;

    assign imem_rdata  = imem[imem_addr];
    assign dmem_rdata  = dmem[dmem_addr];
    assign imem_rdata2 = imem2[imem_addr2];
    assign dmem_rdata2 = 32'h0;

    pipe_core_fwd u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .ADV        (ADV),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dmem_addr  (dmem_addr),
        .dmem_rdata (dmem_rdata),
        .dmem_we    (dmem_we),
        .dmem_wdata (dmem_wdata),
        .dbg_ra     (dbg_ra),
        .dbg_rd     (dbg_rd),
        .stall      (stall),
        .flush      (flush),
        .retired    (retired)
    );

    pipe_core_fwd #(.DATA_W(32), .ADDR_W(6), .CNT_W(16)) u_dut32 (
        .CLK        (CLK),
        .RST        (RST2),
        .ADV        (ADV2),
        .imem_addr  (imem_addr2),
        .imem_rdata (imem_rdata2),
        .dmem_addr  (dmem_addr2),
        .dmem_rdata (dmem_rdata2),
        .dmem_we    (dmem_we2),
        .dmem_wdata (dmem_wdata2),
        .dbg_ra     (dbg_ra2),
        .dbg_rd     (dbg_rd2),
        .stall      (stall2),
        .flush      (flush2),
        .retired    (retired2)
    );

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'h0;
            dmem[i] = 16'h0;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        ADV = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        n_stall = 0;
        n_flush = 0;
        n_we    = 0;
    endtask

    // Advance n cycles, tallying stall/flush/dmem_we seen before each edge.
    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            ADV = 1'b1;
            #1;
            if (stall)   n_stall++;
            if (flush)   n_flush++;
            if (dmem_we) n_we++;
            @(negedge CLK);
        end
        ADV = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem();
        imem[0] = 16'h5105;
        imem[1] = 16'h5203;
        imem[2] = 16'h1123;
        imem[3] = 16'h2314;
        do_reset();
        adv(8);
        RST = 1'b1;
        #1;
        checks++;
        if (imem_addr !== 8'd0) begin
            errors++; $display("FAIL reset_pc: got %0h expected 0", imem_addr);
        end
        checks++;
        if (retired !== 32'd0) begin
            errors++; $display("FAIL reset_retired: got %0d expected 0", retired);
        end
        checks++;
        if ({stall, flush, dmem_we} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000", {stall, flush, dmem_we});
        end
        checks++;
        if ({dmem_addr, dmem_wdata} !== 24'h0) begin
            errors++; $display("FAIL reset_dmem: got %0h expected 0", {dmem_addr, dmem_wdata});
        end
        clear_mem();
        @(negedge CLK);
        RST = 1'b0;
        n_we = 0;
        adv(10);
        checks++;
        if (imem_addr !== 8'd10) begin
            errors++; $display("FAIL idle_pc: got %0d expected 10", imem_addr);
        end
        checks++;
        if (retired !== 32'd0) begin
            errors++; $display("FAIL idle_retired: got %0d expected 0", retired);
        end
        checks++;
        if (n_we !== 0) begin
            errors++; $display("FAIL idle_we: got %0d expected 0", n_we);
        end
        for (int r = 0; r < 16; r++) begin
            dbg_ra = 4'(r);
            #1;
            checks++;
            if (dbg_rd !== 16'h0) begin
                errors++; $display("FAIL idle_reg r%0d: got %0h expected 0", r, dbg_rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_mem();
        imem[0] = 16'h5105;
        imem[1] = 16'h5203;
        imem[2] = 16'h1123;
        imem[3] = 16'h2314;
        do_reset();
        adv(7);
        dbg_ra = 4'd4;
        #1;
        checks++;
        if (dbg_rd !== 16'h0) begin
            errors++; $display("FAIL b2b_r4_early: got %0h expected 0", dbg_rd);
        end
        checks++;
        if (retired !== 32'd3) begin
            errors++; $display("FAIL b2b_retired7: got %0d expected 3", retired);
        end
        adv(1);
        checks++;
        if (retired !== 32'd4) begin
            errors++; $display("FAIL b2b_retired8: got %0d expected 4", retired);
        end
        dbg_ra = 4'd3;
        #1;
        checks++;
        if (dbg_rd !== 16'd8) begin
            errors++; $display("FAIL b2b_r3: got %0h expected 8", dbg_rd);
        end
        dbg_ra = 4'd4;
        #1;
        checks++;
        if (dbg_rd !== 16'd3) begin
            errors++; $display("FAIL b2b_r4: got %0h expected 3", dbg_rd);
        end
        checks++;
        if (n_stall !== 0) begin
            errors++; $display("FAIL b2b_stall: got %0d expected 0", n_stall);
        end
    endtask

    task automatic test_load_use();
        clear_mem();
        dmem[7] = 16'h1234;
        imem[0] = 16'h5507;
        imem[1] = 16'h6650;
        imem[2] = 16'h1667;
        do_reset();
        adv(7);
        dbg_ra = 4'd7;
        #1;
        checks++;
        if (dbg_rd !== 16'h0) begin
            errors++; $display("FAIL lu_r7_early: got %0h expected 0", dbg_rd);
        end
        checks++;
        if (retired !== 32'd2) begin
            errors++; $display("FAIL lu_retired7: got %0d expected 2", retired);
        end
        adv(1);
        #1;
        checks++;
        if (dbg_rd !== 16'h2468) begin
            errors++; $display("FAIL lu_r7: got %0h expected 2468", dbg_rd);
        end
        checks++;
        if (retired !== 32'd3) begin
            errors++; $display("FAIL lu_retired8: got %0d expected 3", retired);
        end
        adv(4);
        dbg_ra = 4'd6;
        #1;
        checks++;
        if (dbg_rd !== 16'h1234) begin
            errors++; $display("FAIL lu_r6: got %0h expected 1234", dbg_rd);
        end
        checks++;
        if (n_stall !== 1) begin
            errors++; $display("FAIL lu_stall_pulses: got %0d expected 1", n_stall);
        end
    endtask

    task automatic test_branch();
        clear_mem();
        imem[0]    = 16'h5000;
        imem[1]    = 16'h8020;
        imem[2]    = 16'h5101;
        imem[3]    = 16'h5202;
        imem[8'h20] = 16'h5333;
        do_reset();
        adv(4);
        checks++;
        if (imem_addr !== 8'h20) begin
            errors++; $display("FAIL br_target: got %0h expected 20", imem_addr);
        end
        checks++;
        if (n_flush !== 1) begin
            errors++; $display("FAIL br_flush_at_redirect: got %0d expected 1", n_flush);
        end
        adv(8);
        checks++;
        if (n_flush !== 1) begin
            errors++; $display("FAIL br_flush_pulses: got %0d expected 1", n_flush);
        end
        checks++;
        if (retired !== 32'd3) begin
            errors++; $display("FAIL br_retired: got %0d expected 3", retired);
        end
        dbg_ra = 4'd1;
        #1;
        checks++;
        if (dbg_rd !== 16'h0) begin
            errors++; $display("FAIL br_r1: got %0h expected 0", dbg_rd);
        end
        dbg_ra = 4'd2;
        #1;
        checks++;
        if (dbg_rd !== 16'h0) begin
            errors++; $display("FAIL br_r2: got %0h expected 0", dbg_rd);
        end
        dbg_ra = 4'd3;
        #1;
        checks++;
        if (dbg_rd !== 16'h0033) begin
            errors++; $display("FAIL br_r3: got %0h expected 33", dbg_rd);
        end
    endtask

    task automatic test_store_adv();
        logic [7:0]  pc0;
        logic [31:0] ret0;
        clear_mem();
        imem[0] = 16'h517F;
        imem[1] = 16'h5209;
        imem[2] = 16'h7120;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            ADV = (i % 2 == 0);
            #1;
            if (dmem_we) begin
                n_we++;
                checks++;
                if ({dmem_addr, dmem_wdata} !== {8'd9, 16'h007F}) begin
                    errors++; $display("FAIL st_addr_data: got %0h/%0h expected 9/7f", dmem_addr, dmem_wdata);
                end
            end
            pc0  = imem_addr;
            ret0 = retired;
            @(negedge CLK);
            if (!ADV) begin
                checks++;
                if ({imem_addr, retired} !== {pc0, ret0}) begin
                    errors++; $display("FAIL st_frozen cycle %0d: got %0h/%0d expected %0h/%0d", i, imem_addr, retired, pc0, ret0);
                end
            end
        end
        ADV = 1'b0;
        checks++;
        if (n_we !== 1) begin
            errors++; $display("FAIL st_we_pulses: got %0d expected 1", n_we);
        end
        checks++;
        if (retired !== 32'd3) begin
            errors++; $display("FAIL st_retired: got %0d expected 3", retired);
        end
        checks++;
        if (imem_addr !== 8'd12) begin
            errors++; $display("FAIL st_pc: got %0d expected 12", imem_addr);
        end
    endtask

    task automatic test_param_sweep();
        for (int i = 0; i < 64; i++) imem2[i] = 16'h0;
        imem2[0] = 16'h51FF;
        RST2 = 1'b1;
        ADV2 = 1'b0;
        @(negedge CLK);
        RST2 = 1'b0;
        repeat (64) begin
            ADV2 = 1'b1;
            @(negedge CLK);
        end
        ADV2 = 1'b0;
        dbg_ra2 = 4'd1;
        #1;
        checks++;
        if (imem_addr2 !== 6'd0) begin
            errors++; $display("FAIL p32_pc_wrap: got %0d expected 0", imem_addr2);
        end
        checks++;
        if (dbg_rd2 !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL p32_sext: got %0h expected ffffffff", dbg_rd2);
        end
        checks++;
        if (retired2 !== 16'd1) begin
            errors++; $display("FAIL p32_retired1: got %0d expected 1", retired2);
        end
        repeat (5) begin
            ADV2 = 1'b1;
            @(negedge CLK);
        end
        ADV2 = 1'b0;
        checks++;
        if (imem_addr2 !== 6'd5) begin
            errors++; $display("FAIL p32_pc: got %0d expected 5", imem_addr2);
        end
        checks++;
        if (retired2 !== 16'd2) begin
            errors++; $display("FAIL p32_retired2: got %0d expected 2", retired2);
        end
    endtask

    initial begin
        RST     = 1'b1;
        ADV     = 1'b0;
        RST2    = 1'b1;
        ADV2    = 1'b0;
        dbg_ra  = 4'd0;
        dbg_ra2 = 4'd0;
        n_stall = 0;
        n_flush = 0;
        n_we    = 0;
        for (int i = 0; i < 64; i++) imem2[i] = 16'h0;
        clear_mem();
        @(negedge CLK);
        test_reset();
        test_back_to_back();
        test_load_use();
        test_branch();
        test_store_adv();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_core_fwd.md
# pipe_core_fwd

Parametrised five-stage (IF/ID/EX/MEM/WB) in-order processor core. It succeeds the fixed 16-bit core and adds three things: generic data and address widths, a full EX-stage forwarding network with load-use stall detection, and a retired-instruction counter. Instruction and data memories are external and combinationally read. A single-cycle advance enable `ADV` replaces the gated pipeline clock, so pause/step logic stays outside the core.

## Interface
- `DATA_W`, default 16: register and datapath width, minimum 8.
- `ADDR_W`, default 8: PC and data-address width, maximum 8.
- `CNT_W`, default 32: retired-counter width.
- `CLK` in 1: core clock; all state changes on its rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `ADV` in 1: pipeline advance enable; when 0 all state holds and no memory or register writes occur.
- `imem_addr` out ADDR_W: equals PC.
- `imem_rdata` in 16: instruction at `imem_addr`, combinational.
- `dmem_addr` out ADDR_W: MEM-stage address.
- `dmem_rdata` in DATA_W: combinational read data.
- `dmem_we` out 1: `ADV` AND (MEM-stage op is ST).
- `dmem_wdata` out DATA_W: MEM-stage store data.
- `dbg_ra` in 4: debug register read address.
- `dbg_rd` out DATA_W: register file [`dbg_ra`], combinational.
- `stall` out 1: load-use stall active this cycle.
- `flush` out 1: EX-stage branch taken this cycle.
- `retired` out CNT_W: count of non-bubble instructions that completed WB.

## Operation
- **Instruction format.** op=[15:12], a=[11:8], b=[7:4], c=[3:0], imm8=[7:0]. `sext(imm8)` is sign-extended to DATA_W.
- **Opcodes.**
  - 0: NOP.
  - 1–4: ADD/SUB/AND/OR, R[c] ← R[a] op R[b].
  - 5: LI, R[a] ← sext(imm8).
  - 6: LD, R[a] ← dmem[R[b][ADDR_W-1:0]].
  - 7: ST, dmem[R[b][ADDR_W-1:0]] ← R[a].
  - 8: BEQZ, if R[a]==0 then PC ← imm8[ADDR_W-1:0].
  - 9–15: execute as NOP and do not count as retired.
- **Source reads.** ALU ops read a and b; LD reads b; ST reads a and b; BEQZ reads a; LI and NOP read nothing.
- **Register file.** 16×DATA_W, all registers writable. A write in WB is visible to an ID read in the same cycle (write-through bypass).
- **Forwarding to EX operands.** Priority is EX/MEM first, then MEM/WB, then the ID/EX value. A source matches only if the producer's regwrite is set and its dest equals the source index. EX/MEM never forwards an LD result.
- **Load-use stall.**
  - Condition: ID/EX holds LD with dest d, and the ID instruction reads d.
  - Effect: PC and IF/ID hold, and a NOP bubble enters ID/EX; `stall`=1.
  - Only one stall cycle is ever needed.
- **Branch.** BEQZ is resolved in EX on the forwarded operand. When taken: PC ← target, IF/ID and ID/EX are replaced by NOP (2-bubble penalty), and `flush`=1.
  - A taken branch overrides a simultaneous stall.
- **Arithmetic.** Arithmetic wraps modulo 2^DATA_W and overflow is ignored. PC+1 wraps modulo 2^ADDR_W.
- **Retired counter.** Increments on each `ADV` edge on which the WB stage holds a valid, non-bubble op in 1–8; it wraps at 2^CNT_W.

## Timing
- **Reset.** `RST` asserted gives, immediately: PC=0, all pipeline registers = NOP/bubble, all registers 0, `retired`=0. Consequently `stall`=`flush`=`dmem_we`=0, `imem_addr`=0, `dmem_addr`=0, `dmem_wdata`=0.
  - Reset mid-operation discards all in-flight instructions, and no write occurs on the reset edge.
- **Throughput.** With `ADV` held at 1, CPI is 1 absent hazards.
  - An instruction fetched on advance k writes back on advance k+4.
  - Its register result is readable via `dbg_rd` after advance k+4.
  - `retired` reflects it after advance k+4.
- **Penalties.** Load-use adds exactly 1 advance; a taken branch adds exactly 2.
- **Freezing.** With `ADV`=0, `stall`/`flush` are still computed combinationally from the held state, but they have no effect until the next advance.
- **Outputs.** `dbg_rd` and all `dmem_*` and `imem_*` outputs are combinational from current state.

## Test plan
- **Reset/idle.** Assert RST mid-program, then release with imem all-zero and ADV=1 for 10 cycles → PC=10, `retired`=0, `dbg_rd`=0 for all registers, `dmem_we` never asserted.
- **Back-to-back forwarding.** LI r1,5; LI r2,3; ADD r3=r1+r2; SUB r4=r3-r1 → r3=8, r4=3, no stall, `retired`=4 after 8 advances.
- **Load-use.** Preload dmem[7]=0x1234. LI r5,7; LD r6←[r5]; ADD r7=r6+r6 → exactly one `stall` pulse, r7=0x2468, ADD retires one advance later than in the hazard-free case.
- **Branch.** LI r0,0; BEQZ r0→0x20; LI r1,1; LI r2,2 at the fall-through PCs → `flush` for one cycle, r1=r2=0, next fetch at 0x20.
- **Store/ADV gating.** LI r1,0x7F; LI r2,9; ST [r2]←r1 with ADV toggling every other cycle → exactly one `dmem_we` pulse, addr 9, data 0x007F, and no state change on ADV=0 cycles.
- **Parameter sweep.** DATA_W=32, ADDR_W=6 → LI r1,-1 gives 0xFFFFFFFF; running PC past 63 wraps to 0; `retired` counts correctly.
